// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants for the FIFO write arbiter: FSM encoding and default sizing.
package fifo_write_arbiter_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_MAX_BURST = 4;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter.
// master drives requests and the full flag; slave is the arbiter.
interface fifo_write_arbiter_if
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH
);

  logic [NUM_REQ-1:0]       req_valid_in;
  logic [NUM_REQ-1:0]       req_last_in;
  logic [NUM_REQ*WIDTH-1:0] req_data_in;
  logic [NUM_REQ-1:0]       req_ready_out;
  logic                     full_in;
  logic                     write_out;
  logic [WIDTH-1:0]         wdata_out;
  logic [NUM_REQ-1:0]       grant_out;
  logic                     busy_out;

  modport master (
    output req_valid_in, req_last_in, req_data_in, full_in,
    input  req_ready_out, write_out, wdata_out, grant_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_last_in, req_data_in, full_in,
    output req_ready_out, write_out, wdata_out, grant_out, busy_out
  );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin pick: first set request searching upward from last_i+1 (wrapping).
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int cand;
    cand   = 0;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_i) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!any_o && req_i[cand]) begin
        any_o        = 1'b1;
        pick_o[cand] = 1'b1;
        idx_o        = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter multiplexing N requesters onto one FIFO write port.
// One IDLE cycle of arbitration per grant; full_in stalls beats combinationally.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 write_clk,
  input  logic                 rst_in,
  fifo_write_arbiter_if.slave  arb
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [0:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic               in_xfer;
  logic               gnt_vld;
  logic               gnt_last;
  logic               beat;
  logic [CNT_W-1:0]   cnt_inc;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i  (arb.req_valid_in),
    .last_i (last_q),
    .pick_o (pick),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign in_xfer  = (state_q == ST_XFER);
  assign gnt_vld  = |(arb.req_valid_in & grant_q);
  assign gnt_last = |(arb.req_last_in & grant_q);
  // Reset forces the handshake quiet even before the registers clear.
  assign beat     = in_xfer && !arb.full_in && gnt_vld && !rst_in;
  assign cnt_inc  = cnt_q + 1'b1;

  assign arb.req_ready_out = (in_xfer && !arb.full_in && !rst_in) ? grant_q : '0;
  assign arb.write_out     = beat;
  assign arb.wdata_out     = arb.req_data_in[gidx_q*WIDTH +: WIDTH];
  assign arb.grant_out     = grant_q;
  assign arb.busy_out      = in_xfer;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == ST_IDLE) begin
      if (pick_any) begin
        state_d = ST_XFER;
        grant_d = pick;
        gidx_d  = pick_idx;
        cnt_d   = '0;
      end
    end else if (!arb.full_in) begin
      // A bubble or a finishing beat both hand the port back.
      if (!gnt_vld || gnt_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
        state_d = ST_IDLE;
        grant_d = '0;
        last_d  = gidx_q;
      end
      if (gnt_vld) begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge write_clk) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: inputs change 1ns after posedge, outputs checked 1ns later.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  logic write_clk;
  logic rst_in;
  int   errs;
  int   checks;

  fifo_write_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) arb ();

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .WIDTH     (8),
    .MAX_BURST (4)
  ) dut (
    .write_clk (write_clk),
    .rst_in    (rst_in),
    .arb       (arb)
  );

  initial write_clk = 1'b0;
  always #5 write_clk = ~write_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [3:0] v, input logic [3:0] l, input logic f);
    @(posedge write_clk);
    #1;
    rst_in           = r;
    arb.req_valid_in = v;
    arb.req_last_in  = l;
    arb.full_in      = f;
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'h0, 4'h0, 1'b0);
    cyc(1'b1, 4'hF, 4'hF, 1'b0);
    check("rst_write", 32'(arb.write_out), 32'h0);
    check("rst_ready", 32'(arb.req_ready_out), 32'h0);
    check("rst_grant", 32'(arb.grant_out), 32'h0);
    check("rst_busy", 32'(arb.busy_out), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g;
    errs             = 0;
    checks           = 0;
    rst_in           = 1'b1;
    arb.req_valid_in = '0;
    arb.req_last_in  = '0;
    arb.full_in      = 1'b0;
    arb.req_data_in  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    // Single requester, last on beat 3
    do_reset();
    cyc(1'b0, 4'h1, 4'h0, 1'b0);
    check("t1_idle_grant", 32'(arb.grant_out), 32'h0);
    check("t1_idle_write", 32'(arb.write_out), 32'h0);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 4'h1, (k == 3) ? 4'h1 : 4'h0, 1'b0);
      check("t1_grant", 32'(arb.grant_out), 32'h1);
      check("t1_write", 32'(arb.write_out), 32'h1);
      check("t1_busy", 32'(arb.busy_out), 32'h1);
      check("t1_wdata", 32'(arb.wdata_out), 32'hA0);
    end
    cyc(1'b0, 4'h0, 4'h0, 1'b0);
    check("t1_end_grant", 32'(arb.grant_out), 32'h0);
    check("t1_end_busy", 32'(arb.busy_out), 32'h0);
    check("t1_end_write", 32'(arb.write_out), 32'h0);

    // All requesters valid, bursts cut at 4 beats, grants 0,1,2,3,0
    do_reset();
    for (int k = 0; k < 25; k++) begin
      cyc(1'b0, 4'hF, 4'h0, 1'b0);
      exp_g = (k % 5 == 0) ? 4'h0 : 4'(1 << ((k / 5) % 4));
      check("t2_grant", 32'(arb.grant_out), 32'(exp_g));
      check("t2_ready", 32'(arb.req_ready_out), 32'(exp_g));
      check("t2_write", 32'(arb.write_out), (k % 5 == 0) ? 32'h0 : 32'h1);
      if (k % 5 != 0) begin
        check("t2_wdata", 32'(arb.wdata_out), 32'hA0 + 32'((k / 5) % 4));
      end
    end

    // Requester 2, full for 5 cycles after beat 2
    do_reset();
    cyc(1'b0, 4'h4, 4'h0, 1'b0);
    check("t3_idle_grant", 32'(arb.grant_out), 32'h0);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 4'h4, 4'h0, (k >= 3 && k <= 7));
      check("t3_grant", 32'(arb.grant_out), 32'h4);
      check("t3_write", 32'(arb.write_out), (k >= 3 && k <= 7) ? 32'h0 : 32'h1);
      check("t3_ready", 32'(arb.req_ready_out), (k >= 3 && k <= 7) ? 32'h0 : 32'h4);
    end
    cyc(1'b0, 4'h0, 4'h0, 1'b0);
    check("t3_end_grant", 32'(arb.grant_out), 32'h0);
    check("t3_end_write", 32'(arb.write_out), 32'h0);

    // Requester 1 drops valid after beat 2; requester 3 is served next
    do_reset();
    cyc(1'b0, 4'h2, 4'h0, 1'b0);
    cyc(1'b0, 4'h2, 4'h0, 1'b0);
    check("t4_grant1", 32'(arb.grant_out), 32'h2);
    check("t4_wdata1", 32'(arb.wdata_out), 32'hA1);
    cyc(1'b0, 4'h2, 4'h0, 1'b0);
    check("t4_beat2", 32'(arb.write_out), 32'h1);
    cyc(1'b0, 4'h8, 4'h0, 1'b0);
    check("t4_bubble_write", 32'(arb.write_out), 32'h0);
    check("t4_bubble_grant", 32'(arb.grant_out), 32'h2);
    cyc(1'b0, 4'h8, 4'h0, 1'b0);
    check("t4_idle_grant", 32'(arb.grant_out), 32'h0);
    check("t4_idle_busy", 32'(arb.busy_out), 32'h0);
    cyc(1'b0, 4'h8, 4'h0, 1'b0);
    check("t4_next_grant", 32'(arb.grant_out), 32'h8);
    check("t4_next_write", 32'(arb.write_out), 32'h1);
    check("t4_next_wdata", 32'(arb.wdata_out), 32'hA3);

    // Reset during beat 2 of requester 1's burst
    do_reset();
    cyc(1'b0, 4'h2, 4'h0, 1'b0);
    cyc(1'b0, 4'h2, 4'h0, 1'b0);
    check("t5_beat1", 32'(arb.write_out), 32'h1);
    cyc(1'b1, 4'h2, 4'h0, 1'b0);
    check("t5_rst_write", 32'(arb.write_out), 32'h0);
    check("t5_rst_ready", 32'(arb.req_ready_out), 32'h0);
    cyc(1'b0, 4'hF, 4'h0, 1'b0);
    check("t5_post_grant", 32'(arb.grant_out), 32'h0);
    check("t5_post_write", 32'(arb.write_out), 32'h0);
    check("t5_post_busy", 32'(arb.busy_out), 32'h0);
    cyc(1'b0, 4'hF, 4'h0, 1'b0);
    check("t5_next_grant", 32'(arb.grant_out), 32'h1);
    check("t5_next_write", 32'(arb.write_out), 32'h1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the FIFO write port (2..8).
REQ-002 SHALL have parameter WIDTH, default 8: data width per beat.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant (1..16).
REQ-004 SHALL have port write_clk  in  1: single clock, the FIFO write-side clock.
REQ-005 SHALL have port rst_in  in  1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid_in  in  NUM_REQ: per-requester beat valid.
REQ-007 SHALL have port req_last_in  in  NUM_REQ: per-requester last beat of packet.
REQ-008 SHALL have port req_data_in  in  NUM_REQ*WIDTH: requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port req_ready_out  out  NUM_REQ: per-requester beat accept.
REQ-010 SHALL have port full_in  in  1: FIFO full flag from the write-pointer block.
REQ-011 SHALL have port write_out  out  1: FIFO write enable, one beat per asserted cycle.
REQ-012 SHALL have port wdata_out  out  WIDTH: FIFO write data.
REQ-013 SHALL have port grant_out  out  NUM_REQ: registered one-hot grant, all-zero when idle.
REQ-014 SHALL have port busy_out  out  1: high while state is XFER.

Function
REQ-015 SHALL implement FSM states IDLE and XFER.
REQ-016 In IDLE with any req_valid_in bit set, SHALL select the first valid requester searching upward from last_grant+1 (modulo NUM_REQ), register it in grant_out, and enter XFER on the next edge (1-cycle arbitration latency).
REQ-017 In IDLE with no valid request, SHALL remain in IDLE with grant_out=0.
REQ-018 In XFER, req_ready_out SHALL equal grant_out gated by !full_in, combinationally; non-granted ready bits SHALL be 0.
REQ-019 A beat SHALL occur in any cycle where the granted valid and ready are both high; write_out SHALL be 1 exactly in beat cycles, and wdata_out SHALL be the granted requester's data.
REQ-020 While full_in=1, SHALL produce no beats, hold the grant, and hold the beat counter (stall, no timeout).
REQ-021 A beat counter (width clog2(MAX_BURST+1)) SHALL clear on grant and increment per beat.
REQ-022 SHALL return to IDLE after a beat with the granted req_last_in=1, or after the beat that makes the count equal MAX_BURST.
REQ-023 SHALL return to IDLE if the granted requester deasserts valid while full_in=0 (bubble ends the grant).
REQ-024 On return to IDLE, last_grant SHALL update to the index just served and grant_out SHALL clear in the same edge.
REQ-025 The IDLE cycle after a grant SHALL be mandatory; back-to-back grants SHALL be separated by exactly one cycle without write_out.
REQ-026 A packet cut by MAX_BURST SHALL resume in a later grant; no beat SHALL be dropped or duplicated.
REQ-027 Valid bits from non-granted requesters SHALL have no effect during XFER.

Reset
REQ-028 With rst_in=1 at an edge: state=IDLE, grant_out=0, beat counter=0, last_grant=NUM_REQ-1 (requester 0 is served first).
REQ-029 While rst_in=1, write_out and all req_ready_out bits SHALL be 0 regardless of inputs; reset mid-burst SHALL abort the burst with no further beats.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding and the default NUM_REQ, WIDTH, MAX_BURST constants.
REQ-031 The round-robin priority search SHALL be a sub-module rr_pick (inputs: request vector, last_grant; output: one-hot pick plus index), purely combinational.

Verification
REQ-032 Reset, then req_valid_in=4'b0001 with last on beat 3, full_in=0 -> grant_out=0001 one cycle later, 3 consecutive write_out pulses, IDLE after beat 3.
REQ-033 All four requesters valid continuously, last never asserted, MAX_BURST=4 -> grants 0,1,2,3,0 in order, each exactly 4 beats, one idle cycle between grants.
REQ-034 Requester 2 granted, full_in=1 for 5 cycles mid-burst -> write_out=0 and req_ready_out=0 for those 5 cycles, grant held, burst completes with beat count unchanged.
REQ-035 Granted requester 1 drops valid after beat 2, requester 3 valid -> return to IDLE, next grant=3 (not 1).
REQ-036 rst_in=1 asserted during beat 2 of a burst -> write_out=0 and grant_out=0 after that edge; next grant goes to requester 0.
